// File: rtl/add5x2_operand_packer.sv
// Collects five 2-bit operands into a packed word for a 5x2 approximate adder
// and accumulates error statistics of the adder result against the exact sum.
module add5x2_operand_packer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_data,
   output logic [9:0]              numin,
   output logic                    pk_valid,
   input  logic                    pk_ready,
   input  logic [3:0]              approx_sum,
   input  logic                    clr,
   output logic signed [4:0]       last_err,
   output logic signed [CNT_W-1:0] err_sum,
   output logic [CNT_W-1:0]        err_cnt,
   output logic [CNT_W-1:0]        word_cnt
);

   // Headroom so base + error can never wrap before the saturation compare.
   localparam int unsigned SW = CNT_W + 6;
   localparam logic signed [SW-1:0] SMAX = {7'b0000000, {(CNT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = {7'b1111111, {(CNT_W-1){1'b0}}};

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;
   logic [2:0] idx;
   logic accept;
   logic handshake;

   logic [3:0]              exact;
   logic signed [4:0]       err_c;
   logic signed [CNT_W-1:0] sum_base;
   logic signed [SW-1:0]    sum_wide;
   logic signed [CNT_W-1:0] es_nxt;
   logic [CNT_W-1:0]        wc_base;
   logic [CNT_W-1:0]        ec_base;
   logic [CNT_W-1:0]        wc_nxt;
   logic [CNT_W-1:0]        ec_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      handshake = 1'b0;
      in_ready  = 1'b0;
      pk_valid  = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid && idx == 3'd4) state_nxt = PRESENT;
         end
         PRESENT: begin
            pk_valid  = 1'b1;
            handshake = pk_ready;
            if (pk_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Exact reference sum and signed adder error for the presented word.
   always_comb begin
      exact = 4'(numin[1:0]) + 4'(numin[3:2]) + 4'(numin[5:4])
            + 4'(numin[7:6]) + 4'(numin[9:8]);
      err_c = signed'(5'(approx_sum) - 5'(exact));
   end

   // Next statistics values; clr coincident with a handshake restarts from zero.
   always_comb begin
      sum_base = clr ? '0 : err_sum;
      wc_base  = clr ? '0 : word_cnt;
      ec_base  = clr ? '0 : err_cnt;
      sum_wide = SW'(sum_base) + SW'(err_c);
      if (sum_wide > SMAX)      es_nxt = SMAX[CNT_W-1:0];
      else if (sum_wide < SMIN) es_nxt = SMIN[CNT_W-1:0];
      else                      es_nxt = sum_wide[CNT_W-1:0];
      wc_nxt = (wc_base == '1) ? wc_base : wc_base + CNT_W'(1);
      ec_nxt = (err_c != 5'sd0 && ec_base != '1) ? ec_base + CNT_W'(1) : ec_base;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx      <= 3'd0;
         numin    <= 10'd0;
         last_err <= 5'sd0;
         err_sum  <= '0;
         err_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         if (accept) begin
            numin[{idx, 1'b0} +: 2] <= in_data;
            idx <= (idx == 3'd4) ? 3'd0 : 3'(idx + 3'd1);
         end
         if (handshake) begin
            last_err <= err_c;
            err_sum  <= es_nxt;
            err_cnt  <= ec_nxt;
            word_cnt <= wc_nxt;
         end else if (clr) begin
            last_err <= 5'sd0;
            err_sum  <= '0;
            err_cnt  <= '0;
            word_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/add5x2_operand_packer.md
ADD5X2_OPERAND_PACKER -- requirements
Module: add5x2_operand_packer

Interface
REQ-001 Parameter: CNT_W, default 16, width of statistics counters (err_sum, err_cnt, word_cnt).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  block accepts operand beat.
REQ-006 in_data  input  2  one unsigned 2-bit operand per beat.
REQ-007 numin  output  10  packed operand word to 5x2 adder; operand i at bits [2i+1:2i].
REQ-008 pk_valid  output  1  numin holds a complete 5-operand word.
REQ-009 pk_ready  input  1  downstream adder result is consumed this cycle.
REQ-010 approx_sum  input  4  adder output for current numin, sampled on pk_valid && pk_ready.
REQ-011 clr  input  1  synchronous statistics clear.
REQ-012 last_err  output  5  signed (approx_sum - exact sum) of most recent completed word.
REQ-013 err_sum  output  CNT_W  signed running sum of last_err values.
REQ-014 err_cnt  output  CNT_W  unsigned count of words with nonzero error.
REQ-015 word_cnt  output  CNT_W  unsigned count of completed words.

Function
REQ-016 FSM shall have two states: COLLECT and PRESENT.
REQ-017 COLLECT: in_ready=1, pk_valid=0; beat accepted when in_valid && in_ready.
REQ-018 Accepted beat shall be written to operand slot idx (3-bit, 0..4), idx then increments.
REQ-019 Acceptance with idx==4 shall set idx=0 and move to PRESENT next cycle; no wrap beyond 4.
REQ-020 PRESENT: in_ready=0, pk_valid=1, numin stable; in_valid ignored.
REQ-021 PRESENT with pk_ready=1 shall return to COLLECT next cycle; pk_ready=0 holds PRESENT indefinitely.
REQ-022 Latency: pk_valid rises the cycle after the 5th beat is accepted; in_ready rises the cycle after handshake completes (one bubble cycle).
REQ-023 Exact sum = zero-extended sum of five 2-bit operands, range 0..15, computed combinationally from numin.
REQ-024 Error = approx_sum - exact, evaluated in 5-bit two's complement (range -15..+15).
REQ-025 On handshake (pk_valid && pk_ready): last_err <= error; word_cnt += 1; err_cnt += 1 if error != 0; err_sum += sign-extended error.
REQ-026 word_cnt and err_cnt shall saturate at 2^CNT_W-1.
REQ-027 err_sum shall saturate at signed max/min of CNT_W bits, never wrap.
REQ-028 clr=1 without handshake: last_err, err_sum, err_cnt, word_cnt <= 0; FSM, idx, numin unaffected.
REQ-029 clr=1 coincident with handshake: statistics <= zero plus this word's update (word_cnt=1, err_sum=error, err_cnt=(error!=0)).
REQ-030 numin slots not yet written in current word retain previous word's values; visible only while pk_valid=0.

Reset
REQ-031 rst_n=0 at rising edge shall force: state=COLLECT, idx=0, numin=0, last_err=0, err_sum=0, err_cnt=0, word_cnt=0.
REQ-032 Reset has priority over clr, handshakes, and any partial word; partial words are discarded.
REQ-033 Outputs during reset cycle: in_ready=1 after reset edge, pk_valid=0.

Verification
REQ-034 Beats 3,3,3,3,3, approx_sum=15, pk_ready=1 -> numin=10'h3FF, last_err=0, word_cnt=1, err_cnt=0, err_sum=0.
REQ-035 Beats 0,0,0,0,0, approx_sum=2 -> last_err=+2, err_cnt=1, err_sum=+2; follow with 1,0,0,0,0, approx_sum=3 -> numin=10'h001, err_sum=+4, word_cnt=2.
REQ-036 pk_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0, numin unchanged, no beat lost/accepted, stats unchanged.
REQ-037 CNT_W=4, 8 words each error +2 -> err_sum saturates at +7; 16 words -> word_cnt saturates at 15.
REQ-038 rst_n=0 after 3 beats, then 5 fresh beats 1,1,1,1,1 -> numin=10'h155, pk_valid one cycle after 5th beat.
REQ-039 clr=1 in handshake cycle after 3 prior words with error -1 -> word_cnt=1, err_sum equals this word's error.
